// File: rtl/compare_arbiter.sv
// compare_arbiter: round-robin time-sharing of one external magnitude comparator.
// Requests are granted one at a time; operands and the tagged result are registered.
module compare_arbiter #(
    parameter int unsigned N_REQ = 4,
    parameter int unsigned WIDTH = 2,
    parameter int unsigned ID_W  = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [N_REQ-1:0]       req_valid,
    input  logic [N_REQ*WIDTH-1:0] req_a,
    input  logic [N_REQ*WIDTH-1:0] req_b,
    output logic [N_REQ-1:0]       req_ready,
    output logic [WIDTH-1:0]       cmp_a,
    output logic [WIDTH-1:0]       cmp_b,
    input  logic                   cmp_lower,
    input  logic                   cmp_greater,
    input  logic                   cmp_equal,
    output logic                   rsp_valid,
    input  logic                   rsp_ready,
    output logic [ID_W-1:0]        rsp_id,
    output logic                   lower,
    output logic                   greater,
    output logic                   equal,
    output logic                   busy,
    output logic                   flag_err
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COMPARE = 2'd1,
        RESP    = 2'd2
    } state_t;

    state_t                 state_q;
    logic [ID_W-1:0]        rr_ptr_q;
    logic [ID_W-1:0]        grant_id_q;
    logic [WIDTH-1:0]       cmp_a_q;
    logic [WIDTH-1:0]       cmp_b_q;
    logic                   rsp_valid_q;
    logic [ID_W-1:0]        rsp_id_q;
    logic                   lower_q;
    logic                   greater_q;
    logic                   equal_q;
    logic                   busy_q;
    logic                   flag_err_q;

    logic [2*N_REQ-1:0]     rot_c;
    logic                   grant_vld_c;
    logic [ID_W-1:0]        grant_idx_c;
    logic [WIDTH-1:0]       grant_a_c;
    logic [WIDTH-1:0]       grant_b_c;
    logic [ID_W-1:0]        rr_next_c;
    logic                   flags_ok_c;

    // Rotate requests so bit 0 is rr_ptr, then pick the lowest set offset.
    always_comb begin
        int unsigned sum;
        sum         = 0;
        grant_vld_c = 1'b0;
        grant_idx_c = '0;
        rot_c       = {req_valid, req_valid} >> rr_ptr_q;
        for (int k = int'(N_REQ) - 1; k >= 0; k--) begin
            if (rot_c[k]) begin
                sum = int'(rr_ptr_q) + k;
                if (sum >= N_REQ) begin
                    sum = sum - N_REQ;
                end
                grant_vld_c = 1'b1;
                grant_idx_c = ID_W'(sum);
            end
        end
    end

    // Select the granted requester's operands.
    always_comb begin
        grant_a_c = '0;
        grant_b_c = '0;
        for (int i = 0; i < int'(N_REQ); i++) begin
            if (grant_idx_c == ID_W'(i)) begin
                grant_a_c = req_a[i*WIDTH +: WIDTH];
                grant_b_c = req_b[i*WIDTH +: WIDTH];
            end
        end
    end

    // Acceptance pulse, only while idle and never during reset.
    always_comb begin
        req_ready = '0;
        for (int i = 0; i < int'(N_REQ); i++) begin
            req_ready[i] = !rst && (state_q == IDLE) && grant_vld_c
                           && (grant_idx_c == ID_W'(i));
        end
    end

    assign rr_next_c  = (grant_idx_c == ID_W'(N_REQ - 1)) ? '0 : grant_idx_c + ID_W'(1);
    assign flags_ok_c = $onehot({cmp_lower, cmp_greater, cmp_equal});

    // Control FSM with registered operands, result and status.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            rr_ptr_q    <= '0;
            grant_id_q  <= '0;
            cmp_a_q     <= '0;
            cmp_b_q     <= '0;
            rsp_valid_q <= 1'b0;
            rsp_id_q    <= '0;
            lower_q     <= 1'b0;
            greater_q   <= 1'b0;
            equal_q     <= 1'b0;
            busy_q      <= 1'b0;
            flag_err_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (grant_vld_c) begin
                        cmp_a_q    <= grant_a_c;
                        cmp_b_q    <= grant_b_c;
                        grant_id_q <= grant_idx_c;
                        rr_ptr_q   <= rr_next_c;
                        busy_q     <= 1'b1;
                        state_q    <= COMPARE;
                    end
                end
                COMPARE: begin
                    lower_q     <= cmp_lower;
                    greater_q   <= cmp_greater;
                    equal_q     <= cmp_equal;
                    rsp_id_q    <= grant_id_q;
                    rsp_valid_q <= 1'b1;
                    if (!flags_ok_c) begin
                        flag_err_q <= 1'b1;
                    end
                    state_q     <= RESP;
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                        busy_q      <= 1'b0;
                        state_q     <= IDLE;
                    end
                end
                default: begin
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign cmp_a     = cmp_a_q;
    assign cmp_b     = cmp_b_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_id    = rsp_id_q;
    assign lower     = lower_q;
    assign greater   = greater_q;
    assign equal     = equal_q;
    assign busy      = busy_q;
    assign flag_err  = flag_err_q;

endmodule

// File: tb/tb_compare_arbiter.sv
// Bench for compare_arbiter: behavioural model + per-cycle compare + directed literals.
module tb_compare_arbiter;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] req_valid = '0;
    logic [3:0] persist   = '0;
    logic [7:0] req_a = '0;
    logic [7:0] req_b = '0;
    logic [3:0] req_ready;
    logic [1:0] cmp_a, cmp_b;
    logic       cmp_lower, cmp_greater, cmp_equal;
    logic       rsp_valid;
    logic       rsp_ready = 1'b1;
    logic [1:0] rsp_id;
    logic       lower, greater, equal, busy, flag_err;
    logic       fault = 1'b0;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    // Behavioural comparator; fault mode drives lower and greater together.
    assign cmp_lower   = fault ? 1'b1 : (cmp_a < cmp_b);
    assign cmp_greater = fault ? 1'b1 : (cmp_a > cmp_b);
    assign cmp_equal   = fault ? 1'b0 : (cmp_a == cmp_b);

    compare_arbiter #(.N_REQ(4), .WIDTH(2), .ID_W(2)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_a(req_a), .req_b(req_b), .req_ready(req_ready),
        .cmp_a(cmp_a), .cmp_b(cmp_b),
        .cmp_lower(cmp_lower), .cmp_greater(cmp_greater), .cmp_equal(cmp_equal),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
        .lower(lower), .greater(greater), .equal(equal),
        .busy(busy), .flag_err(flag_err)
    );

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    // First pending requester at or after position p, wrapping modulo 4.
    function automatic logic [1:0] first_from(input logic [3:0] v, input logic [1:0] p);
        for (int k = 0; k < 4; k++) begin
            if (v[(int'(p) + k) % 4]) return 2'((int'(p) + k) % 4);
        end
        return 2'd0;
    endfunction

    // Model: phase since grant (0 idle, 1 comparing, 2 responding) and the captured transaction.
    logic [1:0] m_ph, m_rr, m_gid, m_a, m_b, m_id;
    logic [2:0] m_fl;
    logic       m_rv, m_err;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_ph <= 2'd0; m_rr <= 2'd0; m_gid <= 2'd0; m_a <= 2'd0; m_b <= 2'd0;
            m_id <= 2'd0; m_fl <= 3'b000; m_rv <= 1'b0; m_err <= 1'b0;
        end else if (m_ph == 2'd0) begin
            if (|req_valid) begin
                m_gid <= first_from(req_valid, m_rr);
                m_a   <= req_a[{first_from(req_valid, m_rr), 1'b0} +: 2];
                m_b   <= req_b[{first_from(req_valid, m_rr), 1'b0} +: 2];
                m_rr  <= first_from(req_valid, m_rr) + 2'd1;
                m_ph  <= 2'd1;
            end
        end else if (m_ph == 2'd1) begin
            m_fl  <= fault ? 3'b110 : {m_a < m_b, m_a > m_b, m_a == m_b};
            m_err <= m_err | fault;
            m_id  <= m_gid;
            m_rv  <= 1'b1;
            m_ph  <= 2'd2;
        end else if (rsp_ready) begin
            m_rv <= 1'b0;
            m_ph <= 2'd0;
        end
    end

    // Per-cycle comparison of every output against the model.
    always @(negedge clk) begin
        logic [3:0] er;
        er = 4'b0000;
        if (!rst && m_ph == 2'd0 && |req_valid) er[first_from(req_valid, m_rr)] = 1'b1;
        chk("req_ready", 8'(req_ready), 8'(er));
        chk("cmp_a", 8'(cmp_a), 8'(m_a));
        chk("cmp_b", 8'(cmp_b), 8'(m_b));
        chk("rsp_valid", 8'(rsp_valid), 8'(m_rv));
        chk("rsp_id", 8'(rsp_id), 8'(m_id));
        chk("flags", 8'({lower, greater, equal}), 8'(m_fl));
        chk("busy", 8'(busy), 8'(m_ph != 2'd0));
        chk("flag_err", 8'(flag_err), 8'(m_err));
    end

    logic [3:0] s_rdy;
    logic [1:0] s_id;
    logic [2:0] s_fl;
    logic       s_rv, s_err, s_busy;

    // One cycle: snapshot outputs mid-cycle, then requesters drop accepted one-shot requests.
    task automatic tick();
        @(negedge clk);
        s_rdy = req_ready; s_rv = rsp_valid; s_id = rsp_id;
        s_fl = {lower, greater, equal}; s_err = flag_err; s_busy = busy;
        @(posedge clk);
        #1;
        req_valid = req_valid & ~(s_rdy & ~persist);
    endtask

    initial begin
        logic [2:0] exp_fl [4];
        logic [1:0] exp_id [8];
        exp_fl = '{3'b001, 3'b100, 3'b010, 3'b001};
        exp_id = '{2'd2, 2'd3, 2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd1};

        // Reset state
        tick(); tick();
        chk("reset rsp_valid", 8'(s_rv), 8'd0);
        chk("reset busy", 8'(s_busy), 8'd0);
        chk("reset cmp_a", 8'(cmp_a), 8'd0);
        @(posedge clk); #1; rst = 1'b0;

        // Single request: requester 0, a=10 b=01
        req_a = 8'h02; req_b = 8'h01; req_valid = 4'b0001;
        tick(); chk("single grant", 8'(s_rdy), 8'h01);
        tick(); chk("single compare rsp_valid", 8'(s_rv), 8'd0);
        tick(); chk("single rsp_valid", 8'(s_rv), 8'd1);
        chk("single rsp_id", 8'(s_id), 8'd0);
        chk("single flags", 8'(s_fl), 8'b010);

        // All four requesting from rr_ptr 0
        @(posedge clk); #1; rst = 1'b1; #2; rst = 1'b0;
        req_a = 8'b10_11_01_00; req_b = 8'b10_01_10_00; req_valid = 4'b1111;
        for (int j = 0; j < 4; j++) begin
            tick(); chk("rr grant", 8'(s_rdy), 8'(4'b0001 << j));
            tick();
            tick(); chk("rr rsp_id", 8'(s_id), 8'(j));
            chk("rr flags", 8'(s_fl), 8'(exp_fl[j]));
        end

        // Fairness from rr_ptr 2: one request from requester 1 first
        req_valid = 4'b0010;
        tick(); tick(); tick();
        persist = 4'b1111; req_valid = 4'b1111;
        for (int j = 0; j < 8; j++) begin
            tick(); tick(); tick();
            chk("fair rsp_id", 8'(s_id), 8'(exp_id[j]));
        end
        persist = 4'b0000; req_valid = 4'b0000;

        // Backpressure while requester 1 waits
        rsp_ready = 1'b0; req_valid = 4'b0001;
        tick(); chk("bp grant", 8'(s_rdy), 8'h01);
        req_valid = req_valid | 4'b0010;
        tick();
        for (int j = 0; j < 5; j++) begin
            tick();
            chk("bp rsp_valid", 8'(s_rv), 8'd1);
            chk("bp rsp_id", 8'(s_id), 8'd0);
            chk("bp flags", 8'(s_fl), 8'b001);
            chk("bp no grant", 8'(s_rdy), 8'h00);
        end
        rsp_ready = 1'b1;
        tick(); chk("bp accept rsp_valid", 8'(s_rv), 8'd1);
        tick(); chk("bp late grant", 8'(s_rdy), 8'h02);
        tick(); tick();

        // Reset during COMPARE
        req_valid = 4'b0010;
        tick(); chk("rst grant", 8'(s_rdy), 8'h02);
        #2; rst = 1'b1; #1;
        chk("async cmp_a", 8'(cmp_a), 8'd0);
        chk("async busy", 8'(busy), 8'd0);
        chk("async req_ready", 8'(req_ready), 8'd0);
        @(posedge clk); #1; rst = 1'b0;
        tick(); chk("dropped rsp", 8'(s_rv), 8'd0);
        tick(); chk("dropped rsp2", 8'(s_rv), 8'd0);
        req_valid = 4'b1111;
        tick(); chk("restart grant", 8'(s_rdy), 8'h01);
        tick(); tick();
        req_valid = 4'b0000;

        // Faulty comparator sets a sticky error
        fault = 1'b1; req_valid = 4'b0100;
        tick(); tick();
        tick(); chk("fault err", 8'(s_err), 8'd1);
        chk("fault flags", 8'(s_fl), 8'b110);
        fault = 1'b0; req_valid = 4'b0100;
        tick(); tick();
        tick(); chk("sticky err", 8'(s_err), 8'd1);
        chk("clean flags", 8'(s_fl), 8'b010);
        @(posedge clk); #1; rst = 1'b1; #1;
        chk("err cleared", 8'(flag_err), 8'd0);
        @(posedge clk); #1; rst = 1'b0;
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/compare_arbiter.md
Name: compare_arbiter

Overview:
- Time-shares one external combinational magnitude_comparator (operands a/b; outputs lower, greater, equal) among N_REQ requesters.
- Round-robin arbitration, valid/ready handshake per requester, registered comparator operands, registered tagged result.
- Sits between requester logic and the single comparator instance; the comparator is instantiated at the parent level.

Parameters:
N_REQ, 4, number of requesters (2..8)
WIDTH, 2, operand width in bits; must match the comparator instance
ID_W, 2, requester id width = clog2(N_REQ)

Ports:
clk  input  1  clock, rising edge
rst  input  1  asynchronous, active-high reset
req_valid  input  N_REQ  request pending, one bit per requester
req_a  input  N_REQ*WIDTH  operand a; requester i at bits [i*WIDTH +: WIDTH]
req_b  input  N_REQ*WIDTH  operand b; same packing as req_a
req_ready  output  N_REQ  one-hot acceptance pulse, one bit per requester
cmp_a  output  WIDTH  registered operand to comparator a
cmp_b  output  WIDTH  registered operand to comparator b
cmp_lower  input  1  comparator lower (a<b)
cmp_greater  input  1  comparator greater (a>b)
cmp_equal  input  1  comparator equal (a==b)
rsp_valid  output  1  result valid
rsp_ready  input  1  consumer accepts result
rsp_id  output  ID_W  index of requester owning the result
lower  output  1  registered result flag
greater  output  1  registered result flag
equal  output  1  registered result flag
busy  output  1  1 when state != IDLE
flag_err  output  1  sticky: sampled comparator flags not one-hot

Behaviour:
- Reset (async, rst=1): state=IDLE; rr_ptr=0; req_ready=0; cmp_a=cmp_b=0; rsp_valid=0; rsp_id=0; lower=greater=equal=0; busy=0; flag_err=0.
- FSM states: IDLE, COMPARE, RESP.
- IDLE:
  - No req_valid bit set: stay in IDLE.
  - Otherwise grant the first set bit scanning rr_ptr, rr_ptr+1, ... mod N_REQ.
  - In that same cycle: req_ready[g]=1 (combinational, single cycle); at the clock edge cmp_a<=req_a[g], cmp_b<=req_b[g], grant_id<=g, rr_ptr<=(g+1) mod N_REQ; go to COMPARE.
- COMPARE (one cycle, comparator settles on registered operands):
  - At the clock edge: lower/greater/equal <= cmp_* flags; rsp_id<=grant_id; rsp_valid<=1; go to RESP.
  - If the sampled flags are not exactly one-hot, set flag_err<=1. It stays set until reset.
- RESP:
  - rsp_valid=1; rsp_id and flags held stable.
  - rsp_ready=1: at the edge rsp_valid<=0, go to IDLE.
  - rsp_ready=0: stay in RESP indefinitely; no new grants.
- Latency: req_ready pulse at cycle T; rsp_valid high from T+2. Best-case throughput is one compare per 3 cycles.
- req_ready is 0 in COMPARE and RESP. req_ready is never asserted to a requester whose req_valid=0. At most one req_ready bit is set at any time.
- Handshake rule: req_valid and operands stay stable until req_ready. Operands are captured only on the req_ready cycle; later changes have no effect.
- cmp_a/cmp_b hold their last value outside grant edges.
- Fairness: a continuously requesting requester is granted within N_REQ grants.
- Simultaneous events: a new req_valid arriving during COMPARE/RESP waits; it is arbitrated in the first IDLE cycle.
- Reset mid-operation: the in-flight transaction is dropped with no response; arbitration restarts from requester 0.
- Comparator contract is unsigned WIDTH-bit compare: lower = (a<b), greater = (a>b), equal = (a==b).

Test Plan:
- Reset then single request: req_valid=4'b0001, a=2'b10, b=2'b01 -> req_ready[0] pulse at T; rsp_valid at T+2; rsp_id=0; greater=1, lower=0, equal=0.
- All four valid, rsp_ready=1, operands (00,00), (01,10), (11,01), (10,10) -> grant order 0,1,2,3; results equal, lower, greater, equal; each response 3 cycles apart.
- Fairness: req_valid=4'b1111 held for 8 responses, starting rr_ptr=2 -> ids 2,3,0,1,2,3,0,1.
- Backpressure: rsp_ready=0 for 5 cycles in RESP, requester 1 waiting -> rsp_valid, rsp_id and flags stable; req_ready stays 0; grant to 1 in the first IDLE cycle after acceptance.
- Reset mid-op: assert rst during COMPARE -> all outputs 0 immediately (asynchronous); no rsp_valid after release; next grant starts from requester 0.
- Faulty comparator model drives lower=greater=1 -> flag_err=1 after COMPARE and stays 1 across later transactions until rst.
